// File: rtl/lpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_pkg
//  Description : Shared LPC encoder definitions: default frame geometry and
//                the result-reader state encoding.
//  Revision    : 1.0
// ============================================================================
package lpc_pkg;

   // Frame geometry shared by autocorrelation, Levinson, inverse filter and
   // result reader blocks.
   localparam int LPC_ORDER     = 10;
   localparam int LPC_FRAME_LEN = 160;
   localparam int LPC_DATA_W    = 16;

   typedef enum logic [2:0] {
      RD_IDLE  = 3'd0,
      RD_COEF  = 3'd1,
      RD_RES   = 3'd2,
      RD_DRAIN = 3'd3,
      RD_DONE  = 3'd4
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/lpc_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_skid_fifo
//  Description : Two-entry FIFO with registered head. Slot 0 (q) is always
//                the oldest word so the output comes straight from a flop.
//  Revision    : 1.0
// ============================================================================
module lpc_skid_fifo #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_slot1;

   assign valid = (count != 2'd0);

   // Shift-style storage: pops move slot 1 into the head, pushes land in the
   // first free slot. The caller never pushes into a full FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count   <= 2'd0;
         q       <= '0;
         r_slot1 <= '0;
      end else if (flush) begin
         count   <= 2'd0;
         q       <= '0;
         r_slot1 <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) q <= data;
               else               r_slot1 <= data;
               count <= count + 2'd1;
            end
            2'b01: begin
               q     <= r_slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  q <= data;
               end else begin
                  q       <= r_slot1;
                  r_slot1 <= data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/lpc_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_result_reader
//  Description : Streams LPC coefficients a[1..ORDER] then residual
//                e[0..FRAME_LEN-1] from two 1-cycle-latency memories onto a
//                valid/ready port, then pulses rfin.
//  Revision    : 1.0
// ============================================================================
module lpc_result_reader
   import lpc_pkg::*;
#(
   parameter int ORDER     = LPC_ORDER,
   parameter int FRAME_LEN = LPC_FRAME_LEN,
   parameter int DATA_W    = LPC_DATA_W,
   parameter int A_ADDR_W  = 4,
   parameter int X_ADDR_W  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rready,
   output logic                rfin,
   output logic [A_ADDR_W-1:0] a_raddr,
   input  logic [DATA_W-1:0]   a_rdata,
   output logic [X_ADDR_W-1:0] e_raddr,
   input  logic [DATA_W-1:0]   e_rdata,
   output logic [DATA_W-1:0]   m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_coef,
   output logic                m_last
);

   localparam logic [A_ADDR_W-1:0] c_last_k = A_ADDR_W'(ORDER);
   localparam logic [X_ADDR_W-1:0] c_last_n = X_ADDR_W'(FRAME_LEN - 1);
   localparam int                  c_fifo_w = DATA_W + 2;

   if (ORDER < 1 || FRAME_LEN < 1) begin : g_bad_size
      $fatal(1, "lpc_result_reader: ORDER and FRAME_LEN must be at least 1");
   end
   if ((2 ** A_ADDR_W) <= ORDER || (2 ** X_ADDR_W) < FRAME_LEN) begin : g_bad_addr_w
      $fatal(1, "lpc_result_reader: address width too small for frame geometry");
   end

   rd_state_t             r_state;
   logic                  r_fl_vld;
   logic                  r_fl_coef;
   logic                  r_fl_last;
   logic [1:0]            w_count;
   logic                  w_fifo_valid;
   logic [c_fifo_w-1:0]   w_fifo_q;
   logic [c_fifo_w-1:0]   w_push_data;
   logic                  w_pop;
   logic                  w_active;
   logic                  w_issue;
   logic                  w_abort;
   logic [2:0]            w_occ;

   // Occupancy counts the word leaving this cycle as already gone, so a
   // steady m_ready sustains one read per cycle while never exceeding 2.
   assign w_pop    = w_fifo_valid & m_ready;
   assign w_occ    = 3'(w_count) + 3'(r_fl_vld) - 3'(w_pop);
   assign w_active = (r_state == RD_COEF) || (r_state == RD_RES);
   assign w_issue  = rready && w_active && (w_occ < 3'd2);
   assign w_abort  = !rready && (w_active || (r_state == RD_DRAIN));

   // Returning memory word tagged with the flags captured at issue time.
   assign w_push_data = {r_fl_last, r_fl_coef, (r_fl_coef ? a_rdata : e_rdata)};

   lpc_skid_fifo #(
      .WIDTH (c_fifo_w)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (w_abort),
      .push  (r_fl_vld),
      .data  (w_push_data),
      .pop   (w_pop),
      .count (w_count),
      .valid (w_fifo_valid),
      .q     (w_fifo_q)
   );

   assign m_valid = w_fifo_valid;
   assign m_data  = w_fifo_q[DATA_W-1:0];
   assign m_coef  = w_fifo_valid & w_fifo_q[DATA_W];
   assign m_last  = w_fifo_valid & w_fifo_q[DATA_W+1];

   // Read sequencer: address registers double as the k/n counters and always
   // hold the address of the next read to issue.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= RD_IDLE;
         a_raddr   <= '0;
         e_raddr   <= '0;
         rfin      <= 1'b0;
         r_fl_vld  <= 1'b0;
         r_fl_coef <= 1'b0;
         r_fl_last <= 1'b0;
      end else begin
         rfin     <= 1'b0;
         r_fl_vld <= w_issue;
         if (w_issue) begin
            r_fl_coef <= (r_state == RD_COEF);
            r_fl_last <= (r_state == RD_RES) && (e_raddr == c_last_n);
         end
         case (r_state)
            RD_IDLE: begin
               if (rready) begin
                  r_state <= RD_COEF;
                  a_raddr <= A_ADDR_W'(1);
               end
            end
            RD_COEF: begin
               if (!rready) begin
                  r_state <= RD_IDLE;
               end else if (w_issue) begin
                  if (a_raddr == c_last_k) begin
                     r_state <= RD_RES;
                     e_raddr <= '0;
                  end else begin
                     a_raddr <= a_raddr + A_ADDR_W'(1);
                  end
               end
            end
            RD_RES: begin
               if (!rready) begin
                  r_state <= RD_IDLE;
               end else if (w_issue) begin
                  if (e_raddr == c_last_n) r_state <= RD_DRAIN;
                  else                     e_raddr <= e_raddr + X_ADDR_W'(1);
               end
            end
            RD_DRAIN: begin
               if (!rready) begin
                  r_state <= RD_IDLE;
               end else if (w_occ == 3'd0) begin
                  r_state <= RD_DONE;
                  rfin    <= 1'b1;
               end
            end
            RD_DONE:  r_state <= RD_IDLE;
            default:  r_state <= RD_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lpc_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpc_result_reader
//  Description : Self-checking bench for lpc_result_reader. A small frame
//                (ORDER=2, FRAME_LEN=4) covers exact timing, stall, abort and
//                reset; a full-size frame covers random back-pressure.
//  Revision    : 1.0
// ============================================================================
module tb_lpc_result_reader;
   import lpc_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        rready_s = 1'b0, m_ready_s = 1'b0;
   logic        rfin_s, m_valid_s, m_coef_s, m_last_s;
   logic [3:0]  a_raddr_s;
   logic [7:0]  e_raddr_s;
   logic [15:0] a_rdata_s, e_rdata_s, m_data_s;

   logic        rready_l = 1'b0, m_ready_l = 1'b0;
   logic        rfin_l, m_valid_l, m_coef_l, m_last_l;
   logic [3:0]  a_raddr_l;
   logic [7:0]  e_raddr_l;
   logic [15:0] a_rdata_l, e_rdata_l, m_data_l;

   int checks   = 0;
   int failures = 0;

   // Scoreboards: {last, coef, data}
   logic [17:0] q_s[$];
   logic [17:0] q_l[$];

   always #5 clk = ~clk;

   function automatic logic [15:0] coef_val(input int k);
      return 16'(k * 17);
   endfunction

   function automatic logic [15:0] res_val(input int n);
      return 16'(256 + n);
   endfunction

   // Synchronous-read memory models, 1-cycle latency
   always @(posedge clk) begin
      a_rdata_s <= coef_val(int'(a_raddr_s));
      e_rdata_s <= res_val(int'(e_raddr_s));
      a_rdata_l <= coef_val(int'(a_raddr_l));
      e_rdata_l <= res_val(int'(e_raddr_l));
   end

   lpc_result_reader #(
      .ORDER(2), .FRAME_LEN(4), .DATA_W(16), .A_ADDR_W(4), .X_ADDR_W(8)
   ) dut_s (
      .clk(clk), .reset(reset), .rready(rready_s), .rfin(rfin_s),
      .a_raddr(a_raddr_s), .a_rdata(a_rdata_s),
      .e_raddr(e_raddr_s), .e_rdata(e_rdata_s),
      .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready_s),
      .m_coef(m_coef_s), .m_last(m_last_s)
   );

   lpc_result_reader #(
      .ORDER(10), .FRAME_LEN(160), .DATA_W(16), .A_ADDR_W(4), .X_ADDR_W(8)
   ) dut_l (
      .clk(clk), .reset(reset), .rready(rready_l), .rfin(rfin_l),
      .a_raddr(a_raddr_l), .a_rdata(a_rdata_l),
      .e_raddr(e_raddr_l), .e_rdata(e_rdata_l),
      .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready_l),
      .m_coef(m_coef_l), .m_last(m_last_l)
   );

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (m_valid_s !== 1'b0 || rfin_s !== 1'b0 || m_last_s !== 1'b0 || m_coef_s !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: got valid=%b rfin=%b last=%b coef=%b expected all 0",
                  m_valid_s, rfin_s, m_last_s, m_coef_s);
      end
      checks++;
      if (m_data_s !== 16'h0 || a_raddr_s !== 4'h0 || e_raddr_s !== 8'h0) begin
         failures++;
         $display("FAIL reset_data: got data=%h a=%h e=%h expected 0", m_data_s, a_raddr_s, e_raddr_s);
      end
      checks++;
      if (m_valid_l !== 1'b0 || rfin_l !== 1'b0 || m_data_l !== 16'h0 || a_raddr_l !== 4'h0) begin
         failures++;
         $display("FAIL reset_large: got valid=%b rfin=%b data=%h a=%h expected 0",
                  m_valid_l, rfin_l, m_data_l, a_raddr_l);
      end
      checks++;
      if (dut_s.r_state !== RD_IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d expected %0d", dut_s.r_state, RD_IDLE);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // One small frame; stall_end > 0 holds m_ready low over cycles 3..stall_end.
   task automatic run_small_frame(input int stall_end);
      int          hs;
      int          rfin_n;
      int          rfin_cyc;
      logic [17:0] exp_w;
      logic        stalled;
      q_s.delete();
      for (int i = 1; i <= 2; i++) q_s.push_back({1'b0, 1'b1, coef_val(i)});
      for (int n = 0; n < 4; n++) q_s.push_back({(n == 3) ? 1'b1 : 1'b0, 1'b0, res_val(n)});
      hs = 0; rfin_n = 0; rfin_cyc = -1;
      @(negedge clk);
      rready_s  = 1'b1;
      m_ready_s = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         stalled = (stall_end > 0) && (cyc >= 3) && (cyc <= stall_end);
         if (cyc == 1) begin
            checks++;
            if (a_raddr_s !== 4'd1) begin
               failures++;
               $display("FAIL first_addr: got %0d expected 1", a_raddr_s);
            end
         end
         if (stalled) begin
            checks++;
            if (m_valid_s !== 1'b1 || m_data_s !== 16'h0011 || m_coef_s !== 1'b1) begin
               failures++;
               $display("FAIL stall_hold cyc %0d: got valid=%b data=%h coef=%b expected 1/0011/1",
                        cyc, m_valid_s, m_data_s, m_coef_s);
            end
         end
         if (stall_end > 0 && cyc == stall_end) begin
            checks++;
            if (a_raddr_s !== 4'd2 || e_raddr_s !== 8'd0) begin
               failures++;
               $display("FAIL stall_issue: got a=%0d e=%0d expected a=2 e=0", a_raddr_s, e_raddr_s);
            end
         end
         m_ready_s = stalled ? 1'b0 : 1'b1;
         if (m_valid_s && m_ready_s) begin
            checks++;
            if (q_s.size() == 0) begin
               failures++;
               $display("FAIL small_word: got extra word %h expected none", m_data_s);
            end else begin
               exp_w = q_s.pop_front();
               if ({m_last_s, m_coef_s, m_data_s} !== exp_w) begin
                  failures++;
                  $display("FAIL small_word %0d: got %h expected %h", hs, {m_last_s, m_coef_s, m_data_s}, exp_w);
               end
            end
            if (stall_end == 0) begin
               checks++;
               if (cyc != 3 + hs) begin
                  failures++;
                  $display("FAIL word_cycle %0d: got cycle %0d expected %0d", hs, cyc, 3 + hs);
               end
            end
            hs++;
         end
         if (rfin_s === 1'b1) begin
            rfin_n++;
            if (rfin_cyc < 0) rfin_cyc = cyc;
            rready_s = 1'b0;
         end
         if (rfin_cyc >= 0 && cyc == rfin_cyc + 1) break;
      end
      rready_s = 1'b0;
      checks++;
      if (hs != 6 || q_s.size() != 0) begin
         failures++;
         $display("FAIL small_count: got %0d words (%0d left) expected 6 (0 left)", hs, q_s.size());
      end
      checks++;
      if (rfin_n != 1) begin
         failures++;
         $display("FAIL small_rfin: got %0d pulses expected 1", rfin_n);
      end
      if (stall_end == 0) begin
         checks++;
         if (rfin_cyc != 9) begin
            failures++;
            $display("FAIL rfin_cycle: got %0d expected 9", rfin_cyc);
         end
      end
      checks++;
      if (dut_s.r_state !== RD_IDLE) begin
         failures++;
         $display("FAIL end_state: got %0d expected %0d", dut_s.r_state, RD_IDLE);
      end
   endtask

   task automatic test_basic();
      run_small_frame(0);
   endtask

   task automatic test_stall();
      run_small_frame(10);
   endtask

   task automatic test_random();
      int          hs;
      int          rfin_n;
      int          rfin_cyc;
      logic        prev_hold;
      logic [17:0] prev_w;
      logic [17:0] exp_w;
      q_l.delete();
      for (int k = 1; k <= 10; k++) q_l.push_back({1'b0, 1'b1, coef_val(k)});
      for (int n = 0; n < 160; n++) q_l.push_back({(n == 159) ? 1'b1 : 1'b0, 1'b0, res_val(n)});
      hs = 0; rfin_n = 0; rfin_cyc = -1; prev_hold = 1'b0; prev_w = '0;
      @(negedge clk);
      rready_l = 1'b1;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(negedge clk);
         if (prev_hold) begin
            checks++;
            if (m_valid_l !== 1'b1 || {m_last_l, m_coef_l, m_data_l} !== prev_w) begin
               failures++;
               $display("FAIL hold_stable: got valid=%b word=%h expected 1/%h",
                        m_valid_l, {m_last_l, m_coef_l, m_data_l}, prev_w);
            end
         end
         m_ready_l = 1'($urandom_range(0, 1));
         prev_hold = m_valid_l && !m_ready_l;
         prev_w    = {m_last_l, m_coef_l, m_data_l};
         if (m_valid_l && m_ready_l) begin
            checks++;
            if (q_l.size() == 0) begin
               failures++;
               $display("FAIL rand_word: got extra word %h expected none", m_data_l);
            end else begin
               exp_w = q_l.pop_front();
               if ({m_last_l, m_coef_l, m_data_l} !== exp_w) begin
                  failures++;
                  $display("FAIL rand_word %0d: got %h expected %h", hs, {m_last_l, m_coef_l, m_data_l}, exp_w);
               end
            end
            hs++;
         end
         if (rfin_l === 1'b1) begin
            rfin_n++;
            if (rfin_cyc < 0) rfin_cyc = cyc;
            rready_l = 1'b0;
         end
         if (rfin_cyc >= 0 && cyc == rfin_cyc + 3) break;
      end
      rready_l  = 1'b0;
      m_ready_l = 1'b0;
      checks++;
      if (hs != 170 || q_l.size() != 0) begin
         failures++;
         $display("FAIL rand_count: got %0d words (%0d left) expected 170 (0 left)", hs, q_l.size());
      end
      checks++;
      if (rfin_n != 1) begin
         failures++;
         $display("FAIL rand_rfin: got %0d pulses expected 1", rfin_n);
      end
   endtask

   task automatic test_abort();
      int          hs;
      int          bad;
      logic [17:0] exp_w;
      q_s.delete();
      for (int i = 1; i <= 2; i++) q_s.push_back({1'b0, 1'b1, coef_val(i)});
      for (int n = 0; n < 4; n++) q_s.push_back({(n == 3) ? 1'b1 : 1'b0, 1'b0, res_val(n)});
      hs = 0; bad = 0;
      @(negedge clk);
      rready_s  = 1'b1;
      m_ready_s = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (m_valid_s && m_ready_s) begin
            checks++;
            exp_w = q_s.pop_front();
            if ({m_last_s, m_coef_s, m_data_s} !== exp_w) begin
               failures++;
               $display("FAIL abort_word %0d: got %h expected %h", hs, {m_last_s, m_coef_s, m_data_s}, exp_w);
            end
            hs++;
         end
         if (hs == 3) break;
      end
      rready_s = 1'b0;
      checks++;
      if (hs != 3) begin
         failures++;
         $display("FAIL abort_reach: got %0d handshakes expected 3", hs);
      end
      @(negedge clk);
      checks++;
      if (m_valid_s !== 1'b0 || dut_s.r_state !== RD_IDLE) begin
         failures++;
         $display("FAIL abort_next: got valid=%b state=%0d expected 0/%0d", m_valid_s, dut_s.r_state, RD_IDLE);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (m_valid_s !== 1'b0 || rfin_s !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
      end
      q_s.delete();
      run_small_frame(0);
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      @(negedge clk);
      rready_s  = 1'b1;
      m_ready_s = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (dut_s.r_state !== RD_RES || m_valid_s !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got state=%0d valid=%b expected %0d/1", dut_s.r_state, m_valid_s, RD_RES);
      end
      #2;
      reset    = 1'b0;
      rready_s = 1'b0;
      #1;
      checks++;
      if (m_valid_s !== 1'b0 || m_data_s !== 16'h0 || m_coef_s !== 1'b0 || m_last_s !== 1'b0 ||
          a_raddr_s !== 4'h0 || e_raddr_s !== 8'h0 || rfin_s !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got valid=%b data=%h coef=%b last=%b a=%h e=%h rfin=%b expected all 0",
                  m_valid_s, m_data_s, m_coef_s, m_last_s, a_raddr_s, e_raddr_s, rfin_s);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (m_valid_s !== 1'b0 || dut_s.r_state !== RD_IDLE || a_raddr_s !== 4'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL idle_after_reset: got %0d non-idle cycles expected 0", bad);
      end
      run_small_frame(0);
   endtask

   task automatic test_back_to_back();
      run_small_frame(0);
      run_small_frame(0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/lpc_result_reader.md
Name: lpc_result_reader

Overview:
- Downstream stage of the LPC encoder control FSM; active while the control FSM sits in its finish state with `rready` high.
- Reads LPC coefficients a[1..ORDER] from the coefficient memory, then residual e[0..FRAME_LEN-1] from the residual memory. Both memories are synchronous-read with 1-cycle latency.
- Streams all words out on a valid/ready interface, then pulses `rfin` so the encoder returns to idle.

Parameters:
- ORDER, 10, number of LPC coefficients emitted (addresses 1..ORDER).
- FRAME_LEN, 160, residual samples per frame (addresses 0..FRAME_LEN-1).
- DATA_W, 16, word width of both memories and the output stream.
- A_ADDR_W, 4, coefficient address width; must satisfy 2^A_ADDR_W > ORDER.
- X_ADDR_W, 8, residual address width; must satisfy 2^X_ADDR_W >= FRAME_LEN.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rready  in  1  from encoder control: results valid in memories.
- rfin  out  1  to encoder control: one-cycle pulse, readout complete.
- a_raddr  out  A_ADDR_W  coefficient memory read address.
- a_rdata  in  DATA_W  coefficient memory data, valid 1 cycle after address.
- e_raddr  out  X_ADDR_W  residual memory read address.
- e_rdata  in  DATA_W  residual memory data, valid 1 cycle after address.
- m_data  out  DATA_W  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts word when m_valid & m_ready.
- m_coef  out  1  1 = word is a coefficient, 0 = residual.
- m_last  out  1  high on the final word of the frame (word ORDER+FRAME_LEN).

Behaviour:
- Reset (async, reset=0): state IDLE, counters 0, FIFO empty.
  - Outputs during reset: m_valid=0, rfin=0, m_last=0, m_coef=0, m_data=0, a_raddr=0, e_raddr=0.
- FSM states: IDLE, COEF, RES, DRAIN, DONE.
  - IDLE: when rready=1, go to COEF; coefficient counter k=1, residual counter n=0.
  - COEF: each issue cycle drives a_raddr=k and k++. After issuing k=ORDER, go to RES.
  - RES: each issue cycle drives e_raddr=n and n++. After issuing n=FRAME_LEN-1, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to DONE.
  - DONE: rfin=1 for exactly one cycle, then unconditionally go to IDLE. rready is 0 by the next cycle (control FSM back in idle), so no restart occurs.
- Issue rule: a read issues only when (FIFO occupancy + reads in flight) < 2. This guarantees no overflow under any m_ready pattern.
- Returning data is tagged with the m_coef and m_last flags set at issue time.
- Output buffer: 2-entry FIFO, registered output.
  - m_data, m_coef and m_last are stable while m_valid=1 and m_ready=0.
- Latency: rready seen in IDLE at cycle 0 → first address in cycle 1 → data written at end of cycle 2 → m_valid=1 in cycle 3.
- Throughput: with m_ready held at 1, one word per cycle, no bubbles.
- Completion: the final handshake (m_last word) occurs in cycle t. The FSM reaches DONE in cycle t+1 and pulses rfin in t+1.
- Abort: if rready drops in COEF, RES or DRAIN:
  - next cycle: state IDLE, FIFO flushed, m_valid=0;
  - in-flight data is discarded;
  - rfin is not pulsed.
- Unused address port holds its last value; it is reset to 0.
- Degenerate sizes: ORDER=0 and FRAME_LEN=0 are not supported. Guard with an elaboration-time check.

Decomposition:
- Shared package lpc_pkg holds:
  - the reader state enum (IDLE, COEF, RES, DRAIN, DONE);
  - defaults for ORDER, FRAME_LEN and DATA_W, shared with autocorrelation, Levinson and inverse-filter blocks.
- One sub-module, lpc_skid_fifo: 2-entry FIFO, width DATA_W+2.
  - Ports: push, data, pop, count, valid; async active-low reset.

Test Plan:
- ORDER=2, FRAME_LEN=4, a=[_,0x0011,0x0022], e=[0x0100..0x0103], m_ready=1, rready raised in cycle 0.
  - Outputs 0x0011, 0x0022, 0x0100, 0x0101, 0x0102, 0x0103 in cycles 3..8.
  - m_coef=1 on the first 2 words, m_last only on 0x0103, rfin pulse in cycle 9.
- Same frame, m_ready=0 for cycles 3..10 then 1.
  - m_valid stays high with m_data=0x0011 stable.
  - At most 2 addresses issued before the stall clears.
  - All 6 words delivered in order, none lost or duplicated.
- Random m_ready (50%), ORDER=10, FRAME_LEN=160: scoreboard sees 170 words in order, m_last on word 170, exactly one rfin.
- rready dropped after the 3rd handshake: next cycle m_valid=0, state IDLE, no rfin. A fresh rready then restarts from a[1].
- reset asserted mid-RES: outputs zero immediately (asynchronous). After release the block idles until rready=1.
- Back-to-back frames: rready re-asserted 2 cycles after rfin. Second frame is streamed from a[1] with identical timing.
